// File: rtl/wreg_load_ctrl.sv
// rtl/wreg_load_ctrl.sv - weight register bank load sequencer
//
// Accepts a row-major serial weight stream (one INWD-bit word per beat,
// valid/ready), assembles it into a DIM_OUT x DIM_IN staging array and
// commits the whole array into the weight register with a one-cycle
// enable once the compute datapath is idle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_start   pulse: begin a load (IDLE only)
//   load_abort   pulse: cancel a load in LOAD / WAIT_COMMIT
//   w_valid/w_ready/w_data   weight word stream
//   comp_busy    compute datapath is mid-inference
//   wreg_en      weight register enable (one cycle, COMMIT)
//   wreg_in      packed [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0] staging array
//   wgt_valid    committed weights are usable
//   load_done    one-cycle pulse when the commit occurs
//   busy         controller is not in IDLE
module wreg_load_ctrl #(
    parameter int DIM_OUT = 4,
    parameter int DIM_IN  = 4,
    parameter int INWD    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_start,
    input  logic                            load_abort,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [INWD-1:0]                 w_data,
    input  logic                            comp_busy,
    output logic                            wreg_en,
    output logic [DIM_OUT*DIM_IN*INWD-1:0]  wreg_in,
    output logic                            wgt_valid,
    output logic                            load_done,
    output logic                            busy
);

    localparam int RW = (DIM_OUT > 1) ? $clog2(DIM_OUT) : 1;
    localparam int CW = (DIM_IN > 1) ? $clog2(DIM_IN) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(DIM_OUT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(DIM_IN - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD        = 2'd1,
        WAIT_COMMIT = 2'd2,
        COMMIT      = 2'd3
    } state_t;

    state_t                                    state_q, state_d;
    logic [RW-1:0]                             row_cnt_q, row_cnt_d;
    logic [CW-1:0]                             col_cnt_q, col_cnt_d;
    logic [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0]  stage_q, stage_d;
    logic                                      wgt_valid_q, wgt_valid_d;

    logic beat;
    logic last_beat;

    assign beat      = (state_q == LOAD) && w_valid;
    assign last_beat = beat && (row_cnt_q == ROW_LAST) && (col_cnt_q == COL_LAST);

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        stage_d     = stage_q;
        wgt_valid_d = wgt_valid_q;

        // A beat is always written, even when an abort coincides with it;
        // aborted staging contents are overwritten by the next load.
        if (beat) begin
            stage_d[row_cnt_q][col_cnt_q] = w_data;
        end

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d   = LOAD;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            LOAD: begin
                if (load_abort) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end else if (last_beat) begin
                    state_d   = comp_busy ? WAIT_COMMIT : COMMIT;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end else if (beat) begin
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_COMMIT: begin
                if (load_abort) begin
                    state_d = IDLE;
                end else if (!comp_busy) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Weights are invalid only while the register is being rewritten.
        if (state_q == COMMIT) begin
            wgt_valid_d = 1'b1;
        end else if (state_d == COMMIT) begin
            wgt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            stage_q     <= '0;
            wgt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            stage_q     <= stage_d;
            wgt_valid_q <= wgt_valid_d;
        end
    end

    // Decoded straight from the state flop so an async reset drops the
    // enable immediately and no partial commit can reach the register.
    assign wreg_en   = (state_q == COMMIT);
    assign load_done = (state_q == COMMIT);
    assign w_ready   = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign wgt_valid = wgt_valid_q;
    assign wreg_in   = stage_q;

endmodule

// File: tb/tb_wreg_load_ctrl.sv
// tb/tb_wreg_load_ctrl.sv - directed self-checking bench for wreg_load_ctrl
module tb_wreg_load_ctrl;

    localparam int DIM_OUT = 2;
    localparam int DIM_IN  = 3;
    localparam int INWD    = 8;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           load_start;
    logic                           load_abort;
    logic                           w_valid;
    logic                           w_ready;
    logic [INWD-1:0]                w_data;
    logic                           comp_busy;
    logic                           wreg_en;
    logic [DIM_OUT*DIM_IN*INWD-1:0] wreg_in;
    logic                           wgt_valid;
    logic                           load_done;
    logic                           busy;

    int n_checks = 0;
    int n_fail   = 0;

    wreg_load_ctrl #(.DIM_OUT(DIM_OUT), .DIM_IN(DIM_IN), .INWD(INWD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .comp_busy  (comp_busy),
        .wreg_en    (wreg_en),
        .wreg_in    (wreg_in),
        .wgt_valid  (wgt_valid),
        .load_done  (load_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("busy_in_load", 64'(busy), 64'd1);
        check("w_ready_in_load", 64'(w_ready), 64'd1);
    endtask

    // Send one word; w_valid is left low afterwards so back-to-back calls
    // keep it high across the edge without an idle cycle.
    task automatic send_word(input logic [7:0] d);
        w_valid = 1'b1;
        w_data  = d;
        step();
        w_valid = 1'b0;
        w_data  = 8'hEE;
    endtask

    function automatic logic [7:0] elem(input logic [47:0] words, input int idx);
        return words[8*idx +: 8];
    endfunction

    // Words in beat order (beat i = row i/3, col i%3).
    task automatic expect_commit(input string tag, input logic [47:0] words);
        check({tag, "_wreg_en"}, 64'(wreg_en), 64'd1);
        check({tag, "_load_done"}, 64'(load_done), 64'd1);
        check({tag, "_wgt_valid_low"}, 64'(wgt_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_elem%0d", tag, i), 64'(wreg_in[8*i +: 8]), 64'(elem(words, i)));
        end
        step();
        check({tag, "_wreg_en_drop"}, 64'(wreg_en), 64'd0);
        check({tag, "_load_done_drop"}, 64'(load_done), 64'd0);
        check({tag, "_wgt_valid_set"}, 64'(wgt_valid), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    localparam logic [47:0] W_BASIC = {8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11};
    localparam logic [47:0] W_GAP   = {8'h63, 8'h62, 8'h61, 8'h53, 8'h52, 8'h51};
    localparam logic [47:0] W_BUSY  = {8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
    localparam logic [47:0] W_ABORT = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    localparam logic [47:0] W_RST   = {8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};

    initial begin
        logic [47:0] w;
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        w_valid    = 1'b0;
        w_data     = '0;
        comp_busy  = 1'b0;
        #12;
        check("rst_wreg_en", 64'(wreg_en), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_wgt_valid", 64'(wgt_valid), 64'd0);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wreg_in", 64'(wreg_in), 64'd0);
        rst_n = 1'b1;
        step();

        // w_valid in IDLE must be ignored
        w_valid = 1'b1;
        w_data  = 8'h99;
        step();
        w_valid = 1'b0;
        check("idle_w_ready", 64'(w_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Basic back-to-back load
        w = W_BASIC;
        start_load();
        for (int i = 0; i < 6; i++) send_word(elem(w, i));
        check("basic_r1c2", 64'(wreg_in[(1*DIM_IN+2)*INWD +: INWD]), 64'h23);
        check("basic_r0c0", 64'(wreg_in[0 +: INWD]), 64'h11);
        expect_commit("basic", w);

        // Gapped stream: idle cycle after every beat
        w = W_GAP;
        start_load();
        for (int i = 0; i < 6; i++) begin
            send_word(elem(w, i));
            if (i < 5) begin
                check("gap_still_loading", 64'(w_ready), 64'd1);
                step();
            end
        end
        expect_commit("gap", w);

        // Compute busy on the last beat, held 5 cycles
        w = W_BUSY;
        start_load();
        for (int i = 0; i < 5; i++) send_word(elem(w, i));
        comp_busy = 1'b1;
        send_word(elem(w, 5));
        for (int k = 0; k < 5; k++) begin
            check("wait_w_ready", 64'(w_ready), 64'd0);
            check("wait_wreg_en", 64'(wreg_en), 64'd0);
            check("wait_wgt_valid", 64'(wgt_valid), 64'd1);
            check("wait_busy", 64'(busy), 64'd1);
            if (k < 4) step();
        end
        comp_busy = 1'b0;
        step();
        expect_commit("busywait", w);

        // Abort after 4 beats, then a fresh load
        w = W_ABORT;
        start_load();
        for (int i = 0; i < 4; i++) send_word(8'h70 + 8'(i));
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_wreg_en", 64'(wreg_en), 64'd0);
        check("abort_wgt_valid", 64'(wgt_valid), 64'd1);
        start_load();
        for (int i = 0; i < 6; i++) send_word(elem(w, i));
        check("abort_reload_r0c0", 64'(wreg_in[0 +: INWD]), 64'hA0);
        expect_commit("reload", w);

        // Abort coincident with the last handshake
        start_load();
        for (int i = 0; i < 5; i++) send_word(8'h40 + 8'(i));
        load_abort = 1'b1;
        send_word(8'h45);
        load_abort = 1'b0;
        check("abortlast_wreg_en", 64'(wreg_en), 64'd0);
        check("abortlast_load_done", 64'(load_done), 64'd0);
        check("abortlast_busy", 64'(busy), 64'd0);
        check("abortlast_wgt_valid", 64'(wgt_valid), 64'd1);
        step();
        check("abortlast_no_late_commit", 64'(wreg_en), 64'd0);

        // Reset mid-load, then a full load
        start_load();
        for (int i = 0; i < 3; i++) send_word(8'h80 + 8'(i));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_w_ready", 64'(w_ready), 64'd0);
        check("midrst_wreg_en", 64'(wreg_en), 64'd0);
        check("midrst_wgt_valid", 64'(wgt_valid), 64'd0);
        check("midrst_wreg_in", 64'(wreg_in), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        w = W_RST;
        start_load();
        for (int i = 0; i < 6; i++) send_word(elem(w, i));
        expect_commit("postrst", w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/wreg_load_ctrl.md
Name: wreg_load_ctrl

Overview:
Sequences loading of the FC weight register bank. Accepts a serial weight stream, one INWD-bit word per beat, under valid/ready. Assembles the words into a DIM_OUT x DIM_IN staging array, then commits the whole array into the weight register with a single-cycle enable pulse. The commit only happens while the compute datapath is idle, so weights never change in the middle of an inference.

Parameters:
DIM_OUT, `DIM_OUT, number of output neurons (rows)
DIM_IN, `DIM_IN, number of inputs per neuron (columns)
INWD, `INWD, weight word width in bits

Ports:
clk  input  1  clock
rst_n  input  1  reset
load_start  input  1  one-cycle pulse that begins a weight load
load_abort  input  1  one-cycle pulse that cancels a load in progress
w_valid  input  1  stream word valid
w_ready  output  1  stream word ready
w_data  input  INWD  stream weight word
comp_busy  input  1  compute datapath is mid-inference
wreg_en  output  1  enable to the weight register
wreg_in  output  DIM_OUT*DIM_IN*INWD  packed [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0] staging array
wgt_valid  output  1  committed weights are usable by compute
load_done  output  1  one-cycle pulse when the commit occurs
busy  output  1  controller is not in IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - State returns to IDLE; both counters go to 0.
  - Staging array goes to 0.
  - wreg_en=0, load_done=0, wgt_valid=0, w_ready=0, busy=0.
- FSM states: IDLE, LOAD, WAIT_COMMIT, COMMIT.
- IDLE:
  - w_ready=0.
  - load_start=1 -> LOAD; row_cnt=0, col_cnt=0.
- LOAD:
  - w_ready=1.
  - A beat is accepted when w_valid && w_ready. It writes stage[row_cnt][col_cnt]=w_data.
  - Order is row-major: col_cnt increments first, wraps at DIM_IN-1 to 0, and row_cnt then increments.
  - Last beat is row_cnt==DIM_OUT-1 && col_cnt==DIM_IN-1. On the last beat: comp_busy==0 -> COMMIT, else -> WAIT_COMMIT.
  - Counters clear on leaving LOAD.
- WAIT_COMMIT:
  - w_ready=0.
  - comp_busy==0 -> COMMIT; otherwise stay.
- COMMIT:
  - Lasts exactly one cycle; wreg_en=1 and load_done=1. Next state IDLE.
  - Minimum latency: wreg_en is high in the cycle after the last-beat handshake.
- wreg_in: continuously driven from the staging registers, so it is stable throughout COMMIT.
- wgt_valid (registered):
  - Cleared on the edge entering COMMIT, so it is low during the COMMIT cycle.
  - Set on the edge leaving COMMIT.
  - Otherwise holds. Previously committed weights stay valid during LOAD and WAIT_COMMIT.
- busy = (state != IDLE).
- Priority and boundary cases:
  - load_abort in LOAD or WAIT_COMMIT -> IDLE next cycle. No commit; counters clear; wgt_valid unchanged. Staging contents are don't-care and are overwritten by the next load.
  - load_abort in the same cycle as the last-beat handshake: abort wins. The beat is consumed, but COMMIT is not entered.
  - load_abort in COMMIT or IDLE: ignored.
  - load_start while not in IDLE: ignored.
  - load_start and load_abort together in IDLE: start wins.
  - w_valid outside LOAD: ignored, since w_ready=0.
  - comp_busy is sampled only on the last beat and in WAIT_COMMIT. The compute side must not raise comp_busy while wgt_valid==0.
  - Asynchronous reset mid-load or mid-commit: wreg_en drops immediately. No partial commit reaches the weight register.
- Width rules:
  - row_cnt is $clog2(DIM_OUT) bits, minimum 1.
  - col_cnt is $clog2(DIM_IN) bits, minimum 1.
  - No arithmetic on data; w_data is stored bit-exact.

Test Plan:
Bench overrides DIM_OUT=2, DIM_IN=3, INWD=8.
- Basic load: pulse load_start, then 6 back-to-back beats 0x11,0x12,0x13,0x21,0x22,0x23 with comp_busy=0 -> wreg_en high 1 cycle after the 6th beat; wreg_in[1][2]=0x23 and [0][0]=0x11; load_done pulses once; wgt_valid 0->1 after COMMIT; busy returns to 0.
- Gapped stream: w_valid toggled every other cycle -> exactly 6 words captured, same mapping as the basic load, no duplicates.
- Compute busy: comp_busy=1 at the last beat, held 5 cycles -> controller sits in WAIT_COMMIT and w_ready=0; wreg_en rises 1 cycle after comp_busy falls; wgt_valid from the prior load stays 1 until COMMIT.
- Abort: load_abort after 4 beats -> IDLE next cycle, no wreg_en, wgt_valid unchanged. A new load of 0xA0..0xA5 then commits with [0][0]=0xA0.
- Abort on last beat: load_abort coincident with the 6th handshake -> no COMMIT, no load_done, busy=0 next cycle.
- Reset mid-load: drop rst_n after 3 beats -> all outputs 0 immediately, wgt_valid=0. A subsequent full load succeeds.
